// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and elaboration helpers for param_fifo
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int af_thresh, input int ae_thresh);
    bit ok;
    ok = 1'b1;
    if (width < 1) ok = 1'b0;
    if (depth < 2 || (depth & (depth - 1)) != 0) ok = 1'b0;
    if (af_thresh < 1 || af_thresh > depth) ok = 1'b0;
    if (ae_thresh < 0 || ae_thresh > depth - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH storage, one write port, one registered read port
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Read and write share one block so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - single-clock parametrised FIFO with thresholds and sticky errors
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  generate
    if (!params_ok(WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $error("param_fifo: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_dout_zero;
  logic [PW-1:0]    w_count;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_mem_rdata;
  fifo_status_t     w_status;

  assign w_count = r_wr_ptr - r_rd_ptr;

  always_comb begin
    w_status              = '0;
    w_status.empty        = (w_count == '0);
    w_status.full         = (w_count == PW'(DEPTH));
    w_status.almost_empty = (w_count <= PW'(AE_THRESH));
    w_status.almost_full  = (w_count >= PW'(AF_THRESH));
  end

  // A flush wins over any same-cycle request, so it also gates the memory ports.
  assign w_rd_acc = rd & ~w_status.empty & ~clear;
  assign w_wr_acc = wr & (~w_status.full | rd) & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dout_zero <= 1'b1;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dout_zero <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) begin
        r_rd_ptr    <= r_rd_ptr + PW'(1);
        r_dout_zero <= 1'b0;
      end
      r_overflow  <= r_overflow  | (wr & w_status.full & ~rd);
      r_underflow <= r_underflow | (rd & w_status.empty);
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (data_in),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_mem_rdata)
  );

  // The unreset RAM output is masked to zero after reset/flush until the next read.
  assign data_out     = r_dout_zero ? '0 : w_mem_rdata;
  assign count        = w_count;
  assign empty        = w_status.empty;
  assign full         = w_status.full;
  assign almost_empty = w_status.almost_empty;
  assign almost_full  = w_status.almost_full;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - directed self-checking bench for param_fifo (8x4, AF=3, AE=1)
module tb_param_fifo;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [7:0] data_out;
  logic [2:0] count;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;

  int n_tests;
  int n_fail;

  param_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .wr           (wr),
    .data_in      (data_in),
    .rd           (rd),
    .data_out     (data_out),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flags packed as {empty, full, almost_empty, almost_full, overflow, underflow}
  function automatic logic [5:0] flags();
    return {empty, full, almost_empty, almost_full, overflow, underflow};
  endfunction

  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr = w; rd = r; data_in = d; clear = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clear = 1'b0;
  endtask

  task automatic step_chk(input string tag, input logic [2:0] exp_cnt,
                          input logic [5:0] exp_flags);
    chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    chk({tag, "_flags"}, 32'(flags()), 32'(exp_flags));
  endtask

  initial begin
    logic [7:0] fill_v [4];
    logic [2:0] fill_c [4];
    logic [5:0] fill_f [4];
    logic [7:0] drain_v [4];
    logic [5:0] drain_f [4];
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0; clear = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step_chk("rst", 3'd0, 6'b101000);
    chk("rst_dout", 32'(data_out), 32'h00);

    cyc(1, 0, 8'h77, 0);
    cyc(0, 1, 8'h00, 0);
    chk("pre_dout", 32'(data_out), 32'h77);
    cyc(1, 0, 8'h88, 0);
    step_chk("pre", 3'd1, 6'b001000);
    #2;
    reset_n = 1'b0;
    #1;
    step_chk("async_rst", 3'd0, 6'b101000);
    chk("async_rst_dout", 32'(data_out), 32'h00);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    fill_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill_c = '{3'd1, 3'd2, 3'd3, 3'd4};
    fill_f = '{6'b001000, 6'b000000, 6'b000100, 6'b010100};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, fill_v[i], 0);
      step_chk($sformatf("fill%0d", i), fill_c[i], fill_f[i]);
    end
    cyc(1, 0, 8'h55, 0);
    step_chk("ovf", 3'd4, 6'b010110);
    drain_f = '{6'b000110, 6'b000010, 6'b001010, 6'b101010};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk($sformatf("drain%0d_data", i), 32'(data_out), 32'(fill_v[i]));
      step_chk($sformatf("drain%0d", i), 3'(3 - i), drain_f[i]);
    end

    cyc(1, 0, 8'hB1, 0);
    cyc(1, 0, 8'hB2, 0);
    cyc(1, 0, 8'hB3, 0);
    step_chk("pre_clr", 3'd3, 6'b000110);
    cyc(1, 0, 8'hEE, 1);
    step_chk("clr", 3'd0, 6'b101000);
    chk("clr_dout", 32'(data_out), 32'h00);

    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h01, 0);
    for (int i = 2; i < 10; i++) begin
      cyc(1, 1, 8'(i), 0);
      chk($sformatf("wrap%0d_data", i), 32'(data_out), 32'(i - 2));
      step_chk($sformatf("wrap%0d", i), 3'd2, 6'b000000);
    end
    cyc(0, 1, 8'h00, 0);
    chk("wrap_tail8", 32'(data_out), 32'h08);
    step_chk("wrap_tail8", 3'd1, 6'b001000);
    cyc(0, 1, 8'h00, 0);
    chk("wrap_tail9", 32'(data_out), 32'h09);
    step_chk("wrap_tail9", 3'd0, 6'b101000);

    cyc(1, 0, 8'hA1, 0);
    cyc(1, 0, 8'hA2, 0);
    cyc(1, 0, 8'hA3, 0);
    cyc(1, 0, 8'hA4, 0);
    step_chk("full_pre", 3'd4, 6'b010100);
    cyc(1, 1, 8'hAA, 0);
    chk("full_rw_data", 32'(data_out), 32'hA1);
    step_chk("full_rw", 3'd4, 6'b010100);
    drain_v = '{8'hA2, 8'hA3, 8'hA4, 8'hAA};
    drain_f = '{6'b000100, 6'b000000, 6'b001000, 6'b101000};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk($sformatf("fdrain%0d_data", i), 32'(data_out), 32'(drain_v[i]));
      step_chk($sformatf("fdrain%0d", i), 3'(3 - i), drain_f[i]);
    end

    cyc(1, 1, 8'h5A, 0);
    chk("empty_rw_hold", 32'(data_out), 32'hAA);
    step_chk("empty_rw", 3'd1, 6'b001001);
    cyc(0, 1, 8'h00, 0);
    chk("empty_rw_data", 32'(data_out), 32'h5A);
    step_chk("empty_rw_drain", 3'd0, 6'b101001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
